// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM between an instruction-fetch port
// (read-only) and a data port (read/write). At most one port is granted per
// cycle, and the grant is combinational so a lone requester goes through with
// no arbitration latency. Ties are resolved round-robin by default: the port
// that did not win the last transfer wins. Each accepted read pushes a
// {valid, port} tag into a MEM_LAT-deep shift pipeline. When the tag leaves
// the pipeline, the RAM output is routed back to the right port with a
// one-cycle rvalid pulse.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  - when defined, the data port always wins ties and
//                            the last-grant pointer is removed.
//
// Parameters:
//   ADDR_W   - memory word-address width
//   DATA_W   - data width
//   MEM_LAT  - RAM read latency in cycles (legal range 1..4)
//
// Ports:
//   clock               - single clock; all state changes on its rising edge
//   ctrl_reset          - synchronous active-low reset
//   req_i / addr_i      - fetch request and address (read only)
//   req_d / addr_d      - data request and address
//   we_d / wdata_d      - data-port write enable and write data
//   gnt_i / gnt_d       - combinational accept, same cycle as the request
//   rvalid_i / rvalid_d - one-cycle read-data-valid pulses, from flops
//   rdata               - shared read data; holds its value between pulses
//   mem_addr / mem_wren / mem_data - RAM request, copied from the granted port
//   mem_q               - RAM read data, valid MEM_LAT cycles after the address
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              req_i,
    input  logic              req_d,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic              we_d,
    input  logic [DATA_W-1:0] wdata_d,
    output logic              gnt_i,
    output logic              gnt_d,
    output logic              rvalid_i,
    output logic              rvalid_d,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

`ifndef MEM_ARB_FIXED_PRIO_EN
    port_e last_q;
    port_e last_d;
`endif

    logic               tie_win_i;
    logic [MEM_LAT-1:0] tag_v_q;
    logic [MEM_LAT-1:0] tag_v_d;
    logic [MEM_LAT-1:0] tag_p_q;
    logic [MEM_LAT-1:0] tag_p_d;
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  rdata_d;

    // Arbitration. tie_win_i only matters when both ports request together.
    // Reset gates both grants so nothing reaches the RAM while in reset.
    always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        tie_win_i = 1'b0;
`else
        tie_win_i = (last_q == PORT_D);
`endif
        gnt_i = ctrl_reset && req_i && (!req_d || tie_win_i);
        gnt_d = ctrl_reset && req_d && (!req_i || !tie_win_i);
    end

    // RAM request mux. The fetch port never writes, so its write data is zero.
    always_comb begin
        mem_addr = '0;
        mem_wren = 1'b0;
        mem_data = '0;
        if (gnt_i) begin
            mem_addr = addr_i;
        end else if (gnt_d) begin
            mem_addr = addr_d;
            mem_wren = we_d;
            mem_data = wdata_d;
        end
    end

    // Next-state logic. Reads enter stage 0 of the tag pipeline, and writes
    // leave it empty. The last stage lines up with the cycle in which mem_q
    // carries that read's data. rdata passes mem_q through on a response
    // and otherwise holds its previous value.
    always_comb begin
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d = last_q;
        if (gnt_i) begin
            last_d = PORT_I;
        end else if (gnt_d) begin
            last_d = PORT_D;
        end
`endif
        tag_v_d    = '0;
        tag_p_d    = '0;
        tag_v_d[0] = gnt_i || (gnt_d && !we_d);
        tag_p_d[0] = gnt_d;
        for (int i = 1; i < MEM_LAT; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_p_d[i] = tag_p_q[i-1];
        end

        rvalid_i = tag_v_q[MEM_LAT-1] && !tag_p_q[MEM_LAT-1];
        rvalid_d = tag_v_q[MEM_LAT-1] &&  tag_p_q[MEM_LAT-1];
        rdata    = (rvalid_i || rvalid_d) ? mem_q : rdata_q;
        rdata_d  = rdata;
    end

    // State registers. Reset drops every in-flight read and points the
    // last-grant pointer at the data port, so fetch wins the first tie.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            tag_v_q <= '0;
            tag_p_q <= '0;
            rdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q  <= PORT_D;
`endif
        end else begin
            tag_v_q <= tag_v_d;
            tag_p_q <= tag_p_d;
            rdata_q <= rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule
